// File: rtl/ahb_slave_if_mr.sv
// AHB-side slave interface for the multi-region AHB2APB bridge: region decode, address/data pipeline.
// Define AHB_SLV_IF_ERR_RESP_EN to add the two-cycle ERROR response FSM and saturating err_cnt.
module ahb_slave_if_mr #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_SLV   = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                REG_LOG2  = 26,
  parameter int                ERR_CNT_W = 8
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 hwrite,
  input  logic                 hready_in,
  input  logic [1:0]           htrans,
  input  logic [ADDR_W-1:0]    haddr,
  input  logic [DATA_W-1:0]    hwdata,
  input  logic [DATA_W-1:0]    pr_data,
  input  logic                 fsm_ready,
  output logic                 valid,
  output logic [NUM_SLV-1:0]   temp_selx,
  output logic [NUM_SLV-1:0]   selx_reg,
  output logic [ADDR_W-1:0]    haddr1,
  output logic [ADDR_W-1:0]    haddr2,
  output logic [DATA_W-1:0]    hwdata1,
  output logic [DATA_W-1:0]    hwdata2,
  output logic                 hwrite_reg,
  output logic                 hwrite_reg1,
  output logic [DATA_W-1:0]    hr_data,
  output logic                 hready_out,
  output logic                 hresp,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           dbg_state
);

  logic              active;
  logic              mapped;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] idx;

  assign active = hready_in && (htrans == 2'b10 || htrans == 2'b11);

  // The explicit base compare keeps addresses below the base from wrapping into a region.
  assign off    = haddr - BASE_ADDR;
  assign idx    = off >> REG_LOG2;
  assign mapped = (haddr >= BASE_ADDR) && (idx < ADDR_W'(NUM_SLV));

  always_comb begin
    temp_selx = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (mapped && idx == ADDR_W'(i)) temp_selx[i] = 1'b1;
    end
  end

  assign hr_data = pr_data;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1      <= '0;
      haddr2      <= '0;
      hwdata1     <= '0;
      hwdata2     <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
    end else if (hready_in) begin
      haddr1      <= haddr;
      haddr2      <= haddr1;
      hwdata1     <= hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg  <= hwrite;
      hwrite_reg1 <= hwrite_reg;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)   selx_reg <= '0;
    else if (valid) selx_reg <= temp_selx;
  end

`ifdef AHB_SLV_IF_ERR_RESP_EN
  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_t;

  err_state_t state, state_nxt;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= ST_OK;
    else          state <= state_nxt;
  end

  // The FSM owns hready_out while an ERROR response is in flight, regardless of fsm_ready.
  always_comb begin
    state_nxt  = state;
    hresp      = 1'b0;
    hready_out = fsm_ready;
    case (state)
      ST_OK: begin
        if (active && !mapped) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        hresp      = 1'b1;
        hready_out = 1'b0;
        state_nxt  = ST_ERR2;
      end
      ST_ERR2: begin
        hresp      = 1'b1;
        hready_out = 1'b1;
        state_nxt  = ST_OK;
      end
      default: state_nxt = ST_OK;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      err_cnt <= '0;
    else if (state == ST_ERR1 && err_cnt != {ERR_CNT_W{1'b1}})
      err_cnt <= err_cnt + 1'b1;
  end

  assign valid     = active && mapped && (state == ST_OK);
  assign dbg_state = state;
`else
  assign hresp      = 1'b0;
  assign hready_out = fsm_ready;
  assign err_cnt    = '0;
  assign valid      = active && mapped;
  assign dbg_state  = 2'b00;
`endif

endmodule

// File: tb/tb_ahb_slave_if_mr.sv
// Directed bench for ahb_slave_if_mr: decode, pipeline, wait states and the ERROR response path.
module tb_ahb_slave_if_mr;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hwrite;
  logic        hready_in;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] pr_data;
  logic        fsm_ready;
  logic        valid;
  logic [2:0]  temp_selx;
  logic [2:0]  selx_reg;
  logic [31:0] haddr1, haddr2;
  logic [31:0] hwdata1, hwdata2;
  logic        hwrite_reg, hwrite_reg1;
  logic [31:0] hr_data;
  logic        hready_out;
  logic        hresp;
  logic [1:0]  err_cnt;
  logic [1:0]  dbg_state;

  int n_chk  = 0;
  int n_pass = 0;

  ahb_slave_if_mr #(.ERR_CNT_W(2)) dut (
    .hclk(hclk), .hresetn(hresetn), .hwrite(hwrite), .hready_in(hready_in),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .pr_data(pr_data),
    .fsm_ready(fsm_ready), .valid(valid), .temp_selx(temp_selx),
    .selx_reg(selx_reg), .haddr1(haddr1), .haddr2(haddr2),
    .hwdata1(hwdata1), .hwdata2(hwdata2), .hwrite_reg(hwrite_reg),
    .hwrite_reg1(hwrite_reg1), .hr_data(hr_data), .hready_out(hready_out),
    .hresp(hresp), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic w, input logic [31:0] d);
    htrans = tr;
    haddr  = a;
    hwrite = w;
    hwdata = d;
  endtask

`ifdef AHB_SLV_IF_ERR_RESP_EN
  // One unmapped NONSEQ followed by the full ERR1/ERR2 sequence, with traffic that must be ignored.
  task automatic err_txn(input logic fr, input logic [1:0] exp_cnt);
    fsm_ready = fr;
    drive(NONSEQ, 32'h9000_0000, 1'b0, 32'h0);
    settle();
    chk("err_req_valid", valid, 1'b0);
    chk("err_req_hready", hready_out, fr);
    step();
    drive(NONSEQ, 32'h8000_0000, 1'b0, 32'h0);
    settle();
    chk("err1_valid", valid, 1'b0);
    chk("err1_hresp", hresp, 1'b1);
    chk("err1_hready", hready_out, 1'b0);
    step();
    drive(NONSEQ, 32'h9000_0004, 1'b0, 32'h0);
    settle();
    chk("err2_hresp", hresp, 1'b1);
    chk("err2_hready", hready_out, 1'b1);
    chk("err2_cnt", err_cnt, exp_cnt);
    step();
    drive(IDLE, 32'h0, 1'b0, 32'h0);
    fsm_ready = 1'b1;
    settle();
    chk("ok_hresp", hresp, 1'b0);
    chk("ok_state", dbg_state, 2'd0);
  endtask
`endif

  logic [31:0] dec_addr [5] = '{32'h83FF_FFFC, 32'h8400_0000, 32'h8BFF_FFFC,
                                32'h8C00_0000, 32'h7FFF_FFFC};
  logic [2:0]  dec_sel  [5] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};

  initial begin
    hresetn   = 1'b0;
    hready_in = 1'b1;
    fsm_ready = 1'b1;
    pr_data   = 32'h1234_5678;
    drive(IDLE, 32'h0, 1'b0, 32'h0);
    step();
    step();
    chk("rst_haddr1", haddr1, 32'h0);
    chk("rst_selx_reg", selx_reg, 3'b000);
    chk("rst_err_cnt", err_cnt, 2'd0);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_hready", hready_out, 1'b1);

    // First mapped write and its path through the pipeline
    hresetn = 1'b1;
    drive(NONSEQ, 32'h8000_0010, 1'b1, 32'hA5A5_A5A5);
    settle();
    chk("wr_valid", valid, 1'b1);
    chk("wr_temp_selx", temp_selx, 3'b001);
    chk("hr_data", hr_data, 32'h1234_5678);
    step();
    drive(IDLE, 32'h0, 1'b0, 32'h0);
    settle();
    chk("s1_haddr1", haddr1, 32'h8000_0010);
    chk("s1_hwrite_reg", hwrite_reg, 1'b1);
    chk("s1_hwdata1", hwdata1, 32'hA5A5_A5A5);
    chk("s1_selx_reg", selx_reg, 3'b001);
    step();
    chk("s2_haddr2", haddr2, 32'h8000_0010);
    chk("s2_hwrite_reg1", hwrite_reg1, 1'b1);
    chk("s2_hwdata2", hwdata2, 32'hA5A5_A5A5);
    chk("s2_haddr1", haddr1, 32'h0);
    chk("s2_selx_hold", selx_reg, 3'b001);

    // Region boundaries, all inside one clock period so no unmapped NONSEQ hits an edge
    for (int i = 0; i < 5; i++) begin
      drive(NONSEQ, dec_addr[i], 1'b0, 32'h0);
      settle();
      chk("dec_selx", temp_selx, dec_sel[i]);
      chk("dec_valid", valid, dec_sel[i] != 3'b000);
    end
    drive(IDLE, 32'h9000_0000, 1'b0, 32'h0);
    step();
    settle();
    chk("idle_unmapped_hresp", hresp, 1'b0);
    chk("idle_unmapped_hready", hready_out, 1'b1);

    // Wait states: stage registers hold while hready_in is low
    drive(NONSEQ, 32'h8400_0020, 1'b1, 32'h0000_1111);
    step();
    step();
    chk("ws_pre_haddr2", haddr2, 32'h8400_0020);
    chk("ws_pre_selx", selx_reg, 3'b010);
    hready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(NONSEQ, 32'h8800_0000 + 32'(i * 4), 1'b0, 32'(i));
      settle();
      chk("ws_valid", valid, 1'b0);
      step();
      chk("ws_haddr1", haddr1, 32'h8400_0020);
      chk("ws_haddr2", haddr2, 32'h8400_0020);
      chk("ws_hwdata1", hwdata1, 32'h0000_1111);
    end
    hready_in = 1'b1;
    drive(IDLE, 32'h0, 1'b0, 32'h0);
    step();

`ifdef AHB_SLV_IF_ERR_RESP_EN
    err_txn(1'b1, 2'd1);
    err_txn(1'b0, 2'd2);
    err_txn(1'b1, 2'd3);
    err_txn(1'b0, 2'd3);
    err_txn(1'b1, 2'd3);
    chk("sat_cnt", err_cnt, 2'd3);
    // Reset landing in ERR1 clears without a clock edge
    drive(NONSEQ, 32'h9000_0000, 1'b0, 32'h0);
    step();
    drive(IDLE, 32'h0, 1'b0, 32'h0);
    settle();
    chk("mid_err1_hresp", hresp, 1'b1);
    hresetn = 1'b0;
    settle();
    chk("mid_rst_hresp", hresp, 1'b0);
    chk("mid_rst_cnt", err_cnt, 2'd0);
    chk("mid_rst_state", dbg_state, 2'd0);
    step();
    hresetn = 1'b1;
`else
    fsm_ready = 1'b0;
    drive(NONSEQ, 32'h9000_0000, 1'b0, 32'h0);
    settle();
    chk("off_valid", valid, 1'b0);
    chk("off_hready", hready_out, 1'b0);
    step();
    drive(IDLE, 32'h0, 1'b0, 32'h0);
    settle();
    chk("off_hresp", hresp, 1'b0);
    chk("off_hready_low", hready_out, 1'b0);
    chk("off_cnt", err_cnt, 2'd0);
    fsm_ready = 1'b1;
    settle();
    chk("off_hready_high", hready_out, 1'b1);
    step();
`endif

    // Asynchronous reset of the pipeline mid-cycle
    drive(NONSEQ, 32'h8800_0040, 1'b1, 32'hDEAD_BEEF);
    step();
    step();
    chk("pre_rst_haddr1", haddr1, 32'h8800_0040);
    chk("pre_rst_selx", selx_reg, 3'b100);
    hresetn = 1'b0;
    settle();
    chk("arst_haddr1", haddr1, 32'h0);
    chk("arst_hwdata2", hwdata2, 32'h0);
    chk("arst_selx", selx_reg, 3'b000);
    chk("arst_hwrite_reg", hwrite_reg, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if_mr.md
Name: ahb_slave_if_mr

Overview:
- Parametrised, multi-region successor of the AHB-side slave interface of the AHB2APB bridge.
- Sits between the AHB master and the bridge APB controller FSM.
- Generalises address/data width and number of APB slave regions; adds wait-state-aware pipelining and a registered decode.
- Adds a two-cycle AHB ERROR response for unmapped accesses and a saturating error counter.

Parameters:
- ADDR_W, 32, address width (bits)
- DATA_W, 32, data width (bits)
- NUM_SLV, 3, number of APB slave regions (1..8)
- BASE_ADDR, 32'h8000_0000, base of region 0 (ADDR_W bits)
- REG_LOG2, 26, log2 of region size in bytes (default 64 MB per slave)
- ERR_CNT_W, 8, error counter width

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- hwrite  in  1  AHB write
- hready_in  in  1  AHB HREADY (bus-level)
- htrans  in  2  AHB HTRANS
- haddr  in  ADDR_W  AHB address
- hwdata  in  DATA_W  AHB write data
- pr_data  in  DATA_W  APB read data from bridge FSM
- fsm_ready  in  1  bridge FSM can complete current AHB data phase
- valid  out  1  mapped active transfer this cycle (comb)
- temp_selx  out  NUM_SLV  one-hot region decode of haddr (comb)
- selx_reg  out  NUM_SLV  temp_selx registered on accepted transfer
- haddr1, haddr2  out  ADDR_W  address pipeline stages 1, 2
- hwdata1, hwdata2  out  DATA_W  write-data pipeline stages 1, 2
- hwrite_reg, hwrite_reg1  out  1  hwrite pipeline stages 1, 2
- hr_data  out  DATA_W  read data to AHB (= pr_data)
- hready_out  out  1  slave HREADYOUT
- hresp  out  1  slave HRESP (0 OKAY, 1 ERROR)
- err_cnt  out  ERR_CNT_W  saturating count of ERROR responses

Behaviour:
- Reset (hresetn=0, asynchronous): all pipeline registers, selx_reg and err_cnt cleared to 0; FSM forced to OK; hresp=0.
- active = hready_in & (htrans==NONSEQ(2'b10) | htrans==SEQ(2'b11)).
- Decode:
  - off = haddr - BASE_ADDR
  - mapped = haddr >= BASE_ADDR and (off >> REG_LOG2) < NUM_SLV, using unsigned compare with no wrap-around: an address below the base is unmapped, and the subtraction must not underflow into a mapped region.
  - temp_selx = one-hot bit (off >> REG_LOG2) when mapped, else all zero.
  - Upper boundary is exclusive: BASE_ADDR + NUM_SLV<<REG_LOG2 is unmapped.
- valid = active & mapped & (state==OK).
- Pipeline:
  - haddr1, hwdata1 and hwrite_reg load when hready_in=1; they hold during wait states.
  - Stage 2 loads from stage 1 under the same condition, giving 1-cycle and 2-cycle latency respectively.
  - selx_reg loads temp_selx when valid=1, else holds.
- hr_data = pr_data, combinational, zero latency.
- Error FSM (states OK, ERR1, ERR2):
  - OK: hresp=0, hready_out=fsm_ready. Goes to ERR1 when active & !mapped.
  - ERR1: hresp=1, hready_out=0; err_cnt increments, saturating at all-ones. Always goes to ERR2.
  - ERR2: hresp=1, hready_out=1. Always goes to OK.
  - Any transfer presented during ERR1/ERR2 is ignored: valid=0, no new error. The master cancels per AHB rules.
- Simultaneous events:
  - Unmapped access while fsm_ready=0: the error path still takes effect, and the FSM owns hready_out while in ERR states.
  - IDLE/BUSY htrans to an unmapped address produces no error.
- Reset asserted mid-error returns to OK immediately; err_cnt is cleared.

Optional Feature:
- Macro AHB_SLV_IF_ERR_RESP_EN.
- Defined: error FSM and err_cnt present, as above.
- Undefined: FSM and counter removed; hresp tied 0, err_cnt tied 0, hready_out=fsm_ready. Unmapped transfers are silently dropped (valid=0).

Test Plan:
- Reset release, then NONSEQ write to 32'h8000_0010, hready_in=1 -> valid=1, temp_selx=3'b001; next cycle haddr1=32'h8000_0010, hwrite_reg=1, selx_reg=3'b001; following cycle haddr2=32'h8000_0010.
- Decode boundaries: haddr 32'h83FF_FFFC -> 3'b001; 32'h8400_0000 -> 3'b010; 32'h8BFF_FFFC -> 3'b100; 32'h8C00_0000 and 32'h7FFF_FFFC -> 3'b000, valid=0.
- NONSEQ read to 32'h9000_0000 (macro on) -> next cycle hresp=1/hready_out=0, then hresp=1/hready_out=1, then OK; err_cnt 0->1.
- Wait states: hready_in=0 for 3 cycles with haddr changing -> haddr1/haddr2/hwdata1 hold their values, valid=0.
- err_cnt saturation: ERR_CNT_W=2, five unmapped NONSEQ transfers -> err_cnt=3; assert hresetn=0 during ERR1 -> hresp=0 and err_cnt=0 without waiting for a clock edge.
- Macro off: unmapped NONSEQ -> hresp stays 0, hready_out follows fsm_ready, valid=0.
